sp_job_sched: RTL and testbench
===============================

# sp_job_sched

Round-robin job scheduler that shares a single shortest-path engine among NREQ requesters. It selects one pending graph job, drives the select of the engine's graph-input mux and the engine's valid/hold handshake, and watches for completion with a watchdog. It then returns a tagged response to the winning requester. It sits between the requester ports and the Dijkstra engine.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester index (clog2(NREQ))
- TIMEOUT, 1023, max engine-run cycles before abort (1..65535)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low; clock clk
- req_valid  in  NREQ  per-requester job pending; held until req_ack
- req_ack  out  NREQ  one-cycle pulse, job accepted by engine
- sel  out  IDW  graph-input mux select, stable from LOAD through RESP
- eng_valid  out  1  job presented to engine
- eng_ready  in  1  engine accepts job when high with eng_valid
- eng_done  in  1  engine result valid (engine valid_out)
- eng_hold  out  1  freeze engine outputs while response pending
- resp_valid  out  1  response available
- resp_id  out  IDW  requester owning the response
- resp_error  out  1  response is a timeout abort
- resp_ready  in  1  response consumer accepts
- busy  out  1  state != IDLE
- job_count  out  16  completed responses, wraps 0xFFFF->0

## Operation
- States: IDLE, LOAD, RUN, RESP. Encoding is implementer's choice.
- Pointer last_grant (IDW bits) resets to NREQ-1, so requester 0 has priority after reset.
- IDLE: if any req_valid, pick the first set bit scanning last_grant+1, +2, … modulo NREQ.
  - Register the winner into sel; next state LOAD.
  - If none set, stay in IDLE.
- LOAD:
  - eng_valid=1.
  - If req_valid[sel]=0: withdrawal. Drop eng_valid, return to IDLE, no ack, last_grant unchanged.
  - Else if eng_ready=1: pulse req_ack[sel], clear timer, go to RUN.
  - Else stay in LOAD.
- RUN:
  - eng_valid=0. Timer increments each cycle.
  - eng_done=1: resp_error=0, go to RESP.
  - Else if timer==TIMEOUT-1: resp_error=1, go to RESP.
  - eng_done has priority over timeout in the same cycle.
- RESP:
  - resp_valid=1, resp_id=sel, eng_hold=1.
  - On resp_ready=1: last_grant<=sel, job_count+1 (on error too), go to IDLE.
- eng_done outside RUN is ignored. req_valid changes outside IDLE/LOAD are ignored.
- Reset (any state): state=IDLE, last_grant=NREQ-1, timer=0, job_count=0.

## Timing
- Reset values: req_ack=0, sel=0, eng_valid=0, eng_hold=0, resp_valid=0, resp_id=0, resp_error=0, busy=0, job_count=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- req_valid seen in IDLE at cycle t: eng_valid=1 at t+1.
- Handshake at t+1 with eng_ready=1: req_ack pulses at t+2 and RUN starts at t+2.
- eng_done at cycle d: resp_valid=1 at d+1.
- resp_ready during RESP at cycle r: IDLE at r+1. A new grant is decided at r+1 and eng_valid is asserted at r+2.
- Minimum job turnaround with no stalls: 4 cycles (IDLE→LOAD→RUN→RESP→IDLE).
- Timeout: with no eng_done, RESP is entered exactly TIMEOUT cycles after RUN entry.
- sel holds its value from LOAD until RESP exits. eng_hold is high only in RESP.

## Test plan
- After reset, req_valid=4'b1111, eng_ready=1, eng_done 3 cycles after ack, resp_ready=1 → grant order 0,1,2,3,0; job_count=5 after 5 responses.
- req_valid=4'b0100 only, eng_ready low 5 cycles → eng_valid held 5 cycles with sel=2; single req_ack[2] pulse after eng_ready rises.
- TIMEOUT=8, eng_done never asserted → resp_valid exactly 8 cycles after RUN entry, resp_error=1, resp_id=grantee; next job still grants normally.
- eng_done and timer==TIMEOUT-1 in the same cycle → resp_error=0.
- req_valid[1] dropped during LOAD with eng_ready=0 → return to IDLE, no req_ack, last_grant unchanged; then req 3 is granted.
- Reset held low for one cycle mid-RUN and mid-RESP → next cycle all outputs at reset values, busy=0, job_count=0; requester 0 wins the next arbitration.

Source files
------------

// File: rtl/sp_job_sched_if.sv
// Requester, engine and response handshake bundle for the shared shortest-path
// engine scheduler.
interface sp_job_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ack;
  logic [IDW-1:0]  sel;
  logic            eng_valid;
  logic            eng_ready;
  logic            eng_done;
  logic            eng_hold;
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic            resp_error;
  logic            resp_ready;
  logic            busy;
  logic [15:0]     job_count;

  modport master (
    input  req_valid, eng_ready, eng_done, resp_ready,
    output req_ack, sel, eng_valid, eng_hold, resp_valid, resp_id,
           resp_error, busy, job_count
  );

  modport slave (
    output req_valid, eng_ready, eng_done, resp_ready,
    input  req_ack, sel, eng_valid, eng_hold, resp_valid, resp_id,
           resp_error, busy, job_count
  );
endinterface

// File: rtl/sp_job_sched.sv
// Round-robin scheduler sharing one Dijkstra engine among NREQ requesters,
// with an engine-run watchdog and a tagged response channel.
module sp_job_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  sp_job_sched_if.master     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [15:0]     TMO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [IDW-1:0]  LAST_INIT  = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0   = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [IDW-1:0]  sel_q, sel_d;
  logic [15:0]     timer_q, timer_d;
  logic [15:0]     job_count_q, job_count_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic            eng_valid_q, eng_valid_d;
  logic            eng_hold_q, eng_hold_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_error_q, resp_error_d;
  logic            busy_q, busy_d;

  logic            any_req_s;
  logic [IDW-1:0]  win_s;
  logic [IDW-1:0]  cand_s;
  logic            hit_s;

  // Round-robin pick: first pending requester after last_grant, wrapping.
  always_comb begin
    any_req_s = 1'b0;
    win_s     = '0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s    = IDW'((int'(last_grant_q) + i) % NREQ);
      hit_s     = !any_req_s && bus.req_valid[cand_s];
      win_s     = hit_s ? cand_s : win_s;
      any_req_s = any_req_s | hit_s;
    end
  end

  // Next-state and next-output computation for the scheduler FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    timer_d      = timer_q;
    job_count_d  = job_count_q;
    req_ack_d    = '0;
    resp_error_d = resp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          sel_d   = win_s;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A withdrawn request abandons the grant without moving the pointer.
        if (!bus.req_valid[sel_q]) begin
          state_d = ST_IDLE;
        end else if (bus.eng_ready) begin
          req_ack_d = ONE_HOT0 << sel_q;
          timer_d   = 16'd0;
          state_d   = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (bus.eng_done) begin
          resp_error_d = 1'b0;
          state_d      = ST_RESP;
        end else if (timer_q == TMO_LAST) begin
          resp_error_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          last_grant_d = sel_q;
          job_count_d  = job_count_q + 16'd1;
          resp_error_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    eng_valid_d  = (state_d == ST_LOAD);
    eng_hold_d   = (state_d == ST_RESP);
    resp_valid_d = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_INIT;
      sel_q        <= '0;
      timer_q      <= 16'd0;
      job_count_q  <= 16'd0;
      req_ack_q    <= '0;
      eng_valid_q  <= 1'b0;
      eng_hold_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      timer_q      <= timer_d;
      job_count_q  <= job_count_d;
      req_ack_q    <= req_ack_d;
      eng_valid_q  <= eng_valid_d;
      eng_hold_q   <= eng_hold_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ack    = req_ack_q;
  assign bus.sel        = sel_q;
  assign bus.eng_valid  = eng_valid_q;
  assign bus.eng_hold   = eng_hold_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = sel_q;
  assign bus.resp_error = resp_error_q;
  assign bus.busy       = busy_q;
  assign bus.job_count  = job_count_q;

endmodule

// File: tb/tb_sp_job_sched.sv
// Directed bench for sp_job_sched: round-robin order, stalls, withdrawal,
// watchdog timeout, done/timeout race and mid-job reset.
module tb_sp_job_sched;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   passed = 0;
  int   total  = 0;

  sp_job_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus();

  sp_job_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid = 4'b0000; bus.eng_ready = 1'b0; bus.eng_done = 1'b0; bus.resp_ready = 1'b0;
    tick(); tick();
    total++; if (bus.req_ack !== 4'b0000) $display("FAIL rst_req_ack got %b exp 0000", bus.req_ack); else passed++;
    total++; if (bus.sel !== 2'd0) $display("FAIL rst_sel got %0d exp 0", bus.sel); else passed++;
    total++; if (bus.eng_valid !== 1'b0) $display("FAIL rst_eng_valid got %b exp 0", bus.eng_valid); else passed++;
    total++; if (bus.eng_hold !== 1'b0) $display("FAIL rst_eng_hold got %b exp 0", bus.eng_hold); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", bus.resp_valid); else passed++;
    total++; if (bus.resp_id !== 2'd0) $display("FAIL rst_resp_id got %0d exp 0", bus.resp_id); else passed++;
    total++; if (bus.resp_error !== 1'b0) $display("FAIL rst_resp_error got %b exp 0", bus.resp_error); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy); else passed++;
    total++; if (bus.job_count !== 16'd0) $display("FAIL rst_job_count got %0d exp 0", bus.job_count); else passed++;
    reset = 1'b1;
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL idle_no_req_busy got %b exp 0", bus.busy); else passed++;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [1:0] exp_id;
    logic [3:0] one = 4'b0001;
    bus.req_valid = 4'b1111; bus.eng_ready = 1'b1; bus.resp_ready = 1'b1; bus.eng_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_id = 2'(order[k]);
      tick();
      total++; if (bus.eng_valid !== 1'b1) $display("FAIL rr_eng_valid job%0d got %b exp 1", k, bus.eng_valid); else passed++;
      total++; if (bus.sel !== exp_id) $display("FAIL rr_sel job%0d got %0d exp %0d", k, bus.sel, exp_id); else passed++;
      tick();
      total++; if (bus.req_ack !== (one << exp_id)) $display("FAIL rr_ack job%0d got %b exp %b", k, bus.req_ack, one << exp_id); else passed++;
      total++; if (bus.eng_valid !== 1'b0) $display("FAIL rr_run_eng_valid job%0d got %b exp 0", k, bus.eng_valid); else passed++;
      tick();
      total++; if (bus.req_ack !== 4'b0000) $display("FAIL rr_ack_pulse job%0d got %b exp 0000", k, bus.req_ack); else passed++;
      tick(); tick();
      total++; if (bus.resp_valid !== 1'b0) $display("FAIL rr_early_resp job%0d got %b exp 0", k, bus.resp_valid); else passed++;
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      total++; if (bus.resp_valid !== 1'b1) $display("FAIL rr_resp_valid job%0d got %b exp 1", k, bus.resp_valid); else passed++;
      total++; if (bus.resp_id !== exp_id) $display("FAIL rr_resp_id job%0d got %0d exp %0d", k, bus.resp_id, exp_id); else passed++;
      total++; if (bus.resp_error !== 1'b0) $display("FAIL rr_resp_error job%0d got %b exp 0", k, bus.resp_error); else passed++;
      total++; if (bus.eng_hold !== 1'b1) $display("FAIL rr_eng_hold job%0d got %b exp 1", k, bus.eng_hold); else passed++;
      if (k == 4) bus.req_valid = 4'b0000;
      tick();
      total++; if (bus.busy !== 1'b0) $display("FAIL rr_idle_busy job%0d got %b exp 0", k, bus.busy); else passed++;
      total++; if (bus.job_count !== 16'(k + 1)) $display("FAIL rr_job_count job%0d got %0d exp %0d", k, bus.job_count, k + 1); else passed++;
    end
  endtask

  task automatic test_withdraw();
    bus.req_valid = 4'b1010; bus.eng_ready = 1'b0; bus.resp_ready = 1'b1;
    tick();
    total++; if (bus.eng_valid !== 1'b1 || bus.sel !== 2'd1) $display("FAIL wd_load got ev=%b sel=%0d exp ev=1 sel=1", bus.eng_valid, bus.sel); else passed++;
    bus.req_valid = 4'b1000;
    tick();
    total++; if (bus.eng_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL wd_idle got ev=%b busy=%b exp 0 0", bus.eng_valid, bus.busy); else passed++;
    total++; if (bus.req_ack !== 4'b0000) $display("FAIL wd_no_ack got %b exp 0000", bus.req_ack); else passed++;
    tick();
    total++; if (bus.eng_valid !== 1'b1 || bus.sel !== 2'd3) $display("FAIL wd_regrant got ev=%b sel=%0d exp ev=1 sel=3", bus.eng_valid, bus.sel); else passed++;
    bus.eng_ready = 1'b1;
    tick();
    total++; if (bus.req_ack !== 4'b1000) $display("FAIL wd_ack got %b exp 1000", bus.req_ack); else passed++;
    bus.req_valid = 4'b0000; bus.eng_ready = 1'b0; bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd3) $display("FAIL wd_resp got rv=%b id=%0d exp rv=1 id=3", bus.resp_valid, bus.resp_id); else passed++;
    tick();
    total++; if (bus.job_count !== 16'd6) $display("FAIL wd_job_count got %0d exp 6", bus.job_count); else passed++;
  endtask

  task automatic test_stall();
    int ev_cnt = 0;
    bus.req_valid = 4'b0100; bus.eng_ready = 1'b0; bus.resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.eng_valid === 1'b1 && bus.sel === 2'd2 && bus.req_ack === 4'b0000) ev_cnt++;
    end
    total++; if (ev_cnt != 5) $display("FAIL stall_eng_valid_cycles got %0d exp 5", ev_cnt); else passed++;
    bus.eng_ready = 1'b1;
    tick();
    total++; if (bus.req_ack !== 4'b0100) $display("FAIL stall_ack got %b exp 0100", bus.req_ack); else passed++;
    total++; if (bus.eng_valid !== 1'b0) $display("FAIL stall_run_eng_valid got %b exp 0", bus.eng_valid); else passed++;
    bus.req_valid = 4'b0000; bus.eng_ready = 1'b0;
    tick();
    total++; if (bus.req_ack !== 4'b0000) $display("FAIL stall_ack_pulse got %b exp 0000", bus.req_ack); else passed++;
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2) $display("FAIL stall_resp got rv=%b id=%0d exp rv=1 id=2", bus.resp_valid, bus.resp_id); else passed++;
    tick();
    total++; if (bus.job_count !== 16'd7) $display("FAIL stall_job_count got %0d exp 7", bus.job_count); else passed++;
  endtask

  task automatic test_timeout();
    int early = 0;
    bus.req_valid = 4'b1000; bus.eng_ready = 1'b1; bus.resp_ready = 1'b0;
    tick();
    total++; if (bus.sel !== 2'd3) $display("FAIL to_sel got %0d exp 3", bus.sel); else passed++;
    tick();
    total++; if (bus.req_ack !== 4'b1000) $display("FAIL to_ack got %b exp 1000", bus.req_ack); else passed++;
    bus.req_valid = 4'b0000; bus.eng_ready = 1'b0;
    if (bus.resp_valid !== 1'b0) early++;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      if (bus.resp_valid !== 1'b0) early++;
    end
    total++; if (early != 0) $display("FAIL to_early_resp got %0d cycles exp 0", early); else passed++;
    tick();
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b1) $display("FAIL to_resp got rv=%b err=%b exp 1 1", bus.resp_valid, bus.resp_error); else passed++;
    total++; if (bus.resp_id !== 2'd3 || bus.eng_hold !== 1'b1) $display("FAIL to_resp_id got id=%0d hold=%b exp 3 1", bus.resp_id, bus.eng_hold); else passed++;
    tick();
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b1 || bus.busy !== 1'b1) $display("FAIL to_resp_hold got rv=%b err=%b busy=%b exp 1 1 1", bus.resp_valid, bus.resp_error, bus.busy); else passed++;
    bus.resp_ready = 1'b1;
    tick();
    total++; if (bus.busy !== 1'b0 || bus.job_count !== 16'd8) $display("FAIL to_exit got busy=%b cnt=%0d exp 0 8", bus.busy, bus.job_count); else passed++;
    bus.req_valid = 4'b0001; bus.eng_ready = 1'b1;
    tick();
    total++; if (bus.eng_valid !== 1'b1 || bus.sel !== 2'd0) $display("FAIL to_next_load got ev=%b sel=%0d exp 1 0", bus.eng_valid, bus.sel); else passed++;
    tick();
    total++; if (bus.req_ack !== 4'b0001) $display("FAIL to_next_ack got %b exp 0001", bus.req_ack); else passed++;
    bus.req_valid = 4'b0000; bus.eng_ready = 1'b0; bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b0 || bus.resp_id !== 2'd0) $display("FAIL to_next_resp got rv=%b err=%b id=%0d exp 1 0 0", bus.resp_valid, bus.resp_error, bus.resp_id); else passed++;
    tick();
    total++; if (bus.job_count !== 16'd9) $display("FAIL to_next_count got %0d exp 9", bus.job_count); else passed++;
  endtask

  task automatic test_done_at_timeout();
    bus.req_valid = 4'b0010; bus.eng_ready = 1'b1; bus.resp_ready = 1'b1;
    tick(); tick();
    total++; if (bus.req_ack !== 4'b0010) $display("FAIL race_ack got %b exp 0010", bus.req_ack); else passed++;
    bus.req_valid = 4'b0000; bus.eng_ready = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) tick();
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL race_pre_resp got %b exp 0", bus.resp_valid); else passed++;
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b0 || bus.resp_id !== 2'd1) $display("FAIL race_resp got rv=%b err=%b id=%0d exp 1 0 1", bus.resp_valid, bus.resp_error, bus.resp_id); else passed++;
    tick();
    total++; if (bus.job_count !== 16'd10) $display("FAIL race_count got %0d exp 10", bus.job_count); else passed++;
  endtask

  task automatic test_reset_midflight();
    bus.req_valid = 4'b1111; bus.eng_ready = 1'b1; bus.resp_ready = 1'b0;
    tick();
    total++; if (bus.sel !== 2'd2) $display("FAIL mr_pre_sel got %0d exp 2", bus.sel); else passed++;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++; if ({bus.req_ack, bus.sel, bus.eng_valid, bus.eng_hold, bus.resp_valid, bus.resp_id, bus.resp_error, bus.busy} !== 13'd0)
      $display("FAIL mr_run_outputs got ack=%b sel=%0d ev=%b hold=%b rv=%b id=%0d err=%b busy=%b exp all 0", bus.req_ack, bus.sel, bus.eng_valid, bus.eng_hold, bus.resp_valid, bus.resp_id, bus.resp_error, bus.busy); else passed++;
    total++; if (bus.job_count !== 16'd0) $display("FAIL mr_run_count got %0d exp 0", bus.job_count); else passed++;
    reset = 1'b1;
    tick();
    total++; if (bus.eng_valid !== 1'b1 || bus.sel !== 2'd0) $display("FAIL mr_run_regrant got ev=%b sel=%0d exp 1 0", bus.eng_valid, bus.sel); else passed++;
    tick();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0) $display("FAIL mr_resp got rv=%b id=%0d exp 1 0", bus.resp_valid, bus.resp_id); else passed++;
    reset = 1'b0;
    tick();
    total++; if ({bus.req_ack, bus.sel, bus.eng_valid, bus.eng_hold, bus.resp_valid, bus.resp_id, bus.resp_error, bus.busy} !== 13'd0)
      $display("FAIL mr_resp_outputs got ack=%b sel=%0d ev=%b hold=%b rv=%b id=%0d err=%b busy=%b exp all 0", bus.req_ack, bus.sel, bus.eng_valid, bus.eng_hold, bus.resp_valid, bus.resp_id, bus.resp_error, bus.busy); else passed++;
    total++; if (bus.job_count !== 16'd0) $display("FAIL mr_resp_count got %0d exp 0", bus.job_count); else passed++;
    reset = 1'b1;
    tick();
    total++; if (bus.eng_valid !== 1'b1 || bus.sel !== 2'd0) $display("FAIL mr_resp_regrant got ev=%b sel=%0d exp 1 0", bus.eng_valid, bus.sel); else passed++;
    bus.req_valid = 4'b0000; bus.eng_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_withdraw();
    test_stall();
    test_timeout();
    test_done_at_timeout();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
